// File: rtl/packet_length_tracker.sv
// packet_length_tracker: accumulates aligned flit byte counts into per-packet length records
// queued in a small FIFO, with wrapping packet/byte/drop statistics.
module packet_length_tracker #(
   parameter int LEN_WIDTH  = 16,
   parameter int CNT_WIDTH  = 48,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 snoop_beat,
   input  logic                 snoop_last,
   input  logic [7:0]           bytes_in_flit,
   input  logic                 stats_clear,
   output logic [LEN_WIDTH-1:0] len_tdata,
   output logic                 len_tvalid,
   input  logic                 len_tready,
   output logic [CNT_WIDTH-1:0] pkt_count,
   output logic [CNT_WIDTH-1:0] byte_count,
   output logic [CNT_WIDTH-1:0] drop_count,
   output logic                 in_packet
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic {IDLE, IN_PKT} state_t;
   state_t               state_q, state_d;
   logic                 beat_q, last_q;
   logic [LEN_WIDTH-1:0] acc_q, acc_d, sat;
   logic [LEN_WIDTH:0]   sum;
   logic [LEN_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]          wr_q, rd_q;
   logic [CNT_WIDTH-1:0] pkt_q, byte_q, drop_q;
   logic                 emit, full, empty, pop, push, drop;
   // acc is held at zero in IDLE, so one adder serves both states
   assign sum  = {1'b0, acc_q} + (LEN_WIDTH+1)'(bytes_in_flit);
   assign sat  = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
   assign emit = beat_q & last_q;
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      if (beat_q) begin
         state_d = last_q ? IDLE : IN_PKT;
         acc_d   = last_q ? '0 : sat;
      end
   end
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         acc_q   <= '0;
         beat_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         beat_q  <= snoop_beat;
         last_q  <= snoop_last;
      end
   end
   assign in_packet = (state_q == IN_PKT);
   // pointers carry one extra wrap bit to tell full from empty
   assign empty      = (wr_q == rd_q);
   assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign len_tvalid = ~empty;
   assign len_tdata  = empty ? '0 : mem_q[rd_q[AW-1:0]];
   assign pop        = len_tvalid & len_tready;
   assign push       = emit & (~full | pop);
   assign drop       = emit & full & ~pop;
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= sat;
   end
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_q   <= '0;
         rd_q   <= '0;
         pkt_q  <= '0;
         byte_q <= '0;
         drop_q <= '0;
      end else begin
         wr_q   <= wr_q + (AW+1)'(push);
         rd_q   <= rd_q + (AW+1)'(pop);
         pkt_q  <= stats_clear ? '0 : pkt_q + CNT_WIDTH'(emit);
         byte_q <= stats_clear ? '0 : byte_q + (beat_q ? CNT_WIDTH'(bytes_in_flit) : '0);
         drop_q <= stats_clear ? '0 : drop_q + CNT_WIDTH'(drop);
      end
   end
   assign pkt_count  = pkt_q;
   assign byte_count = byte_q;
   assign drop_count = drop_q;
endmodule
